pll_reset_ctrl: RTL
===================

Name: pll_reset_ctrl

Overview:
- Reset/lock supervisor that sits directly upstream of the 200 MHz PLL wrapper, in the PLL reference-clock domain.
- Drives the PLL's active-high reset input and consumes its asynchronous locked output.
- Sequences power-up reset, waits for lock with timeout and bounded retries, and qualifies lock as stable before raising pll_ready for downstream reset release.
- Detects lock loss and re-sequences the PLL.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 70000: cycles to wait for synced lock after pll_rst release before a retry (100 us at 700 MHz).
- STABLE_CYCLES, 1024: consecutive synced-lock cycles required before pll_ready.
- MAX_RETRIES, 3: timeouts tolerated before FAIL (>=1).
- SYNC_STAGES, 2: flops in the locked synchronizer (>=2).

Ports:
- refclk, input, 1: PLL reference clock; sole clock of this block.
- rst_n, input, 1: asynchronous active-low reset; assertion is async, deassertion is used as-is (pre-synchronized upstream).
- locked_in, input, 1: PLL locked output; asynchronous, synchronized internally.
- restart, input, 1: single-cycle pulse; restarts sequencing from any state.
- pll_rst, output, 1: active-high reset to the PLL.
- pll_ready, output, 1: PLL lock qualified stable.
- fail, output, 1: sticky; retries exhausted.
- state_o, output, 3: current FSM state encoding.
- retry_cnt, output, 2: timeouts in the current sequence; clears on entry to READY or on restart.
- loss_cnt, output, 8: saturating count of lock losses observed in READY.

Behaviour:
- Reset values while rst_n=0: state=RESET, pll_rst=1, pll_ready=0, fail=0, retry_cnt=0, loss_cnt=0, timer=0, synchronizer flops=0.
- lock_s is locked_in after the SYNC_STAGES flops; latency SYNC_STAGES cycles.
- All outputs are registered; a state change is visible on outputs in the same cycle as state_o.
- Encoding: RESET=0, WAIT_LOCK=1, STABLE=2, READY=3, FAIL=4.
- RESET:
  - pll_rst=1; timer counts 0..RST_CYCLES-1.
  - On timer==RST_CYCLES-1, go to WAIT_LOCK and clear the timer.
  - After rst_n rises, pll_rst stays high exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0; timer increments.
  - lock_s=1: go to STABLE, timer=0.
  - Else if timer==LOCK_TIMEOUT-1:
    - retry_cnt+1.
    - If the new value == MAX_RETRIES, go to FAIL; otherwise go to RESET.
  - If lock_s=1 and the timeout land in the same cycle, lock wins.
- STABLE:
  - lock_s=0: go to WAIT_LOCK. The timer restarts at 0; this is not a timeout and does not increment retry_cnt.
  - timer==STABLE_CYCLES-1 with lock_s=1: go to READY, retry_cnt=0.
- READY:
  - pll_ready=1.
  - lock_s=0: in the same cycle pll_ready falls next edge, loss_cnt increments (saturates at 255), state goes to RESET.
- FAIL:
  - pll_rst=1, fail=1, pll_ready=0.
  - Left only via rst_n or restart.
- restart:
  - Accepted in any state: go to RESET, timer=0, retry_cnt=0, fail=0. loss_cnt is preserved.
  - Takes priority over every other transition in the same cycle.
- Timer width is $clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES), plus 1. There is no wrap in any state, because every state exits on its terminal count.
- pll_ready is 1 only in READY. pll_rst is 1 only in RESET and FAIL.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - the state enum (3-bit) and the encodings above;
  - a function computing the timer width.
- One sub-module, sync_bit: an N-stage synchronizer parameterized by SYNC_STAGES with async active-low reset. It is reused for other async status inputs.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3, SYNC_STAGES=2):
- Power-up, locked_in rises 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles after rst_n release; pll_ready rises 2+8 cycles after locked_in; retry_cnt=0.
- locked_in held 0 -> three cycles of 4 reset + 20 wait; retry_cnt goes 1, 2, then FAIL with fail=1, pll_rst=1 permanently. A restart pulse then clears fail and pll_rst falls 4 cycles later.
- In READY, locked_in drops for 1 cycle -> loss_cnt=1, pll_ready=0, state_o=0, re-sequence to READY; force 256 losses -> loss_cnt holds 255.
- In STABLE, locked_in glitches low at timer=5 -> returns to WAIT_LOCK, retry_cnt unchanged, a full 8-cycle stable window is needed again.
- lock_s rises on the same cycle as the WAIT_LOCK timeout -> goes to STABLE, retry_cnt not incremented.
- rst_n asserted mid-WAIT_LOCK and mid-READY -> outputs take their reset values asynchronously within the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reset/lock supervisor: FSM state encoding and timer sizing.
// Combinational definitions only; no latency, no backpressure.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // One spare bit above the largest terminal count keeps every compare in range.
    function automatic int timer_width(input int rst_cycles, input int lock_timeout,
                                       input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m)  m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage synchronizer for one asynchronous level into the clk domain.
// Latency: STAGES clk cycles; no backpressure (level signal, always accepted).
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock supervisor: power-up reset, lock wait with bounded retries, stable-lock qualification.
// Latency: locked_in reaches the FSM after SYNC_STAGES cycles; all outputs registered, updating with state_o.
// No backpressure: restart is a single-cycle pulse accepted in any state.
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 70000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked_in,
    input  logic       restart,
    output logic       pll_rst,
    output logic       pll_ready,
    output logic       fail,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

    logic            lock_s;
    pll_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      retry_q, retry_d, retry_inc;
    logic [7:0]      loss_q, loss_d;
    logic            pll_rst_q, pll_ready_q, fail_q;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (locked_in),
        .q     (lock_s)
    );

    assign retry_inc = retry_q + 2'd1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (restart) begin
            state_d = ST_RESET;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as lock.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        retry_d = retry_inc;
                        timer_d = '0;
                        state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_READY: begin
                    timer_d = '0;
                    if (!lock_s) begin
                        state_d = ST_RESET;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = ST_RESET;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            timer_q     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            pll_ready_q <= (state_d == ST_READY);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign pll_ready = pll_ready_q;
    assign fail      = fail_q;
    assign state_o   = state_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule
